// File: rtl/dvi_pkg.sv
// Shared encodings, widths and colour constants for the DVI pattern source.
package dvi_pkg;

  localparam int COL_W = 11;
  localparam int ROW_W = 10;
  localparam int CMP_W = 12;

  typedef enum logic [1:0] {
    MODE_BARS  = 2'd0,
    MODE_CHECK = 2'd1,
    MODE_GRAD  = 2'd2,
    MODE_BOX   = 2'd3
  } mode_e;

  typedef logic [23:0] rgb_t;

  localparam rgb_t WHITE   = 24'hFFFFFF;
  localparam rgb_t YELLOW  = 24'hFFFF00;
  localparam rgb_t CYAN    = 24'h00FFFF;
  localparam rgb_t GREEN   = 24'h00FF00;
  localparam rgb_t MAGENTA = 24'hFF00FF;
  localparam rgb_t RED     = 24'hFF0000;
  localparam rgb_t BLUE    = 24'h0000FF;
  localparam rgb_t BLACK   = 24'h000000;

  function automatic rgb_t bar_colour(input logic [2:0] idx);
    case (idx)
      3'd0:    return WHITE;
      3'd1:    return YELLOW;
      3'd2:    return CYAN;
      3'd3:    return GREEN;
      3'd4:    return MAGENTA;
      3'd5:    return RED;
      3'd6:    return BLUE;
      default: return BLACK;
    endcase
  endfunction

endpackage

// File: rtl/dvi_box_motion.sv
// One axis of the bouncing box: position and direction, stepped once per frame
// when step_en_i is high; clamps to the edge and reverses on contact.
module dvi_box_motion
  import dvi_pkg::*;
#(
  parameter int LIMIT = 1280,
  parameter int SIZE  = 64,
  parameter int STEP  = 4,
  parameter int W     = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step_en_i,
  output logic [W-1:0] pos_o
);

  localparam logic [CMP_W-1:0] LIMIT_C = CMP_W'(LIMIT);
  localparam logic [CMP_W-1:0] SIZE_C  = CMP_W'(SIZE);
  localparam logic [CMP_W-1:0] STEP_C  = CMP_W'(STEP);

  logic [W-1:0]     pos_q, pos_d;
  logic             fwd_q, fwd_d;
  logic [CMP_W-1:0] pos_ext;

  assign pos_ext = CMP_W'(pos_q);

  always_comb begin
    pos_d = pos_q;
    fwd_d = fwd_q;
    if (step_en_i) begin
      if (fwd_q) begin
        if (pos_ext + SIZE_C + STEP_C >= LIMIT_C) begin
          pos_d = W'(LIMIT - SIZE);
          fwd_d = 1'b0;
        end else begin
          pos_d = pos_q + W'(STEP);
        end
      end else begin
        if (pos_ext <= STEP_C) begin
          pos_d = '0;
          fwd_d = 1'b1;
        end else begin
          pos_d = pos_q - W'(STEP);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pos_q <= '0;
      fwd_q <= 1'b1;
    end else begin
      pos_q <= pos_d;
      fwd_q <= fwd_d;
    end
  end

  assign pos_o = pos_q;

endmodule

// File: rtl/dvi_pattern_gen.sv
// Test-pattern pixel source (bars/checker/gradient/bouncing box), RGB one cycle after address.
// Optional white alignment border on active-area edges when DVI_PATGEN_BORDER_EN is defined.
module dvi_pattern_gen
  import dvi_pkg::*;
#(
  parameter int H_ACTIVE   = 1280,
  parameter int V_ACTIVE   = 720,
  parameter int CHECK_LOG2 = 5,
  parameter int BOX_SIZE   = 64,
  parameter int BOX_STEP   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] column_addr,
  input  logic [9:0]  row_addr,
  input  logic [1:0]  mode,
  output logic [7:0]  red,
  output logic [7:0]  green,
  output logic [7:0]  blue,
  output logic        frame_tick
);

  localparam int ADDR_W = ROW_W + COL_W;
  localparam int BAR_W  = H_ACTIVE / 8;

  localparam logic [CMP_W-1:0]  H_C      = CMP_W'(H_ACTIVE);
  localparam logic [CMP_W-1:0]  V_C      = CMP_W'(V_ACTIVE);
  localparam logic [CMP_W-1:0]  BOX_C    = CMP_W'(BOX_SIZE);
  localparam logic [ADDR_W-1:0] BOUNDARY = {ROW_W'(V_ACTIVE), COL_W'(0)};

  logic [ADDR_W-1:0] addr, prev_addr_q;
  logic              boundary;
  mode_e             active_mode_q, active_mode_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  rgb_t              rgb_q, rgb_d;
  logic              frame_tick_q;

  logic [CMP_W-1:0]  col_ext, row_ext, bx_ext, by_ext;
  logic              active, in_box, checker_bit;
  logic [2:0]        bar_idx;
  logic              bar_found;
  logic [COL_W-1:0]  box_x;
  logic [ROW_W-1:0]  box_y;

  assign addr    = {row_addr, column_addr};
  // Only the first cycle of a held boundary address counts as a new frame.
  assign boundary = (addr == BOUNDARY) && (prev_addr_q != BOUNDARY);

  assign col_ext = CMP_W'(column_addr);
  assign row_ext = CMP_W'(row_addr);
  assign bx_ext  = CMP_W'(box_x);
  assign by_ext  = CMP_W'(box_y);
  assign active  = (col_ext < H_C) && (row_ext < V_C);

  dvi_box_motion #(
    .LIMIT(H_ACTIVE), .SIZE(BOX_SIZE), .STEP(BOX_STEP), .W(COL_W)
  ) u_box_x (
    .clk(clk), .rst(rst), .step_en_i(boundary), .pos_o(box_x)
  );

  dvi_box_motion #(
    .LIMIT(V_ACTIVE), .SIZE(BOX_SIZE), .STEP(BOX_STEP), .W(ROW_W)
  ) u_box_y (
    .clk(clk), .rst(rst), .step_en_i(boundary), .pos_o(box_y)
  );

  // Compare chain instead of a divide; anything past the last full bar stays on bar 7.
  always_comb begin
    bar_idx   = 3'd7;
    bar_found = 1'b0;
    for (int k = 0; k < 7; k++) begin
      if (!bar_found && (col_ext < CMP_W'((k + 1) * BAR_W))) begin
        bar_idx   = 3'(k);
        bar_found = 1'b1;
      end
    end
  end

  assign checker_bit = column_addr[CHECK_LOG2] ^ row_addr[CHECK_LOG2];
  assign in_box = (col_ext >= bx_ext) && (col_ext < bx_ext + BOX_C) &&
                  (row_ext >= by_ext) && (row_ext < by_ext + BOX_C);

  always_comb begin
    rgb_d = BLACK;
    if (active) begin
      case (active_mode_q)
        MODE_BARS:  rgb_d = bar_colour(bar_idx);
        MODE_CHECK: rgb_d = checker_bit ? WHITE : BLACK;
        MODE_GRAD:  rgb_d = {column_addr[7:0], row_addr[7:0], frame_cnt_q};
        MODE_BOX:   rgb_d = in_box ? {frame_cnt_q, ~frame_cnt_q, 8'hFF} : BLACK;
        default:    rgb_d = BLACK;
      endcase
`ifdef DVI_PATGEN_BORDER_EN
      if ((col_ext == 0) || (col_ext == H_C - 1) || (row_ext == 0) || (row_ext == V_C - 1))
        rgb_d = WHITE;
`endif
    end
  end

  always_comb begin
    active_mode_d = active_mode_q;
    frame_cnt_d   = frame_cnt_q;
    if (boundary) begin
      active_mode_d = mode_e'(mode);
      frame_cnt_d   = frame_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rgb_q         <= BLACK;
      frame_tick_q  <= 1'b0;
      active_mode_q <= MODE_BARS;
      frame_cnt_q   <= '0;
      prev_addr_q   <= '1;
    end else begin
      rgb_q         <= rgb_d;
      frame_tick_q  <= boundary;
      active_mode_q <= active_mode_d;
      frame_cnt_q   <= frame_cnt_d;
      prev_addr_q   <= addr;
    end
  end

  assign red        = rgb_q[23:16];
  assign green      = rgb_q[15:8];
  assign blue       = rgb_q[7:0];
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_dvi_pattern_gen.sv
// Directed bench for dvi_pattern_gen with a scoreboard of expected pixels per presented address.
module tb_dvi_pattern_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] column_addr;
  logic [9:0]  row_addr;
  logic [1:0]  mode;
  logic [7:0]  red, green, blue;
  logic        frame_tick;

  always #5 clk = ~clk;

  dvi_pattern_gen dut (
    .clk(clk), .rst(rst), .column_addr(column_addr), .row_addr(row_addr),
    .mode(mode), .red(red), .green(green), .blue(blue), .frame_tick(frame_tick)
  );

  typedef struct {
    logic [23:0] rgb;
    logic        tick;
  } exp_t;

  exp_t  sb[$];
  string tagq[$];
  exp_t  mon_e;
  string mon_t;
  int    checks = 0;
  int    errors = 0;
  int    frames = 0;

  // Blanking forces black; the optional border forces white on active edges.
  function automatic logic [23:0] screen(input int c, input int r, input logic [23:0] v);
    if (c >= 1280 || r >= 720) return 24'h000000;
`ifdef DVI_PATGEN_BORDER_EN
    if (c == 0 || c == 1279 || r == 0 || r == 719) return 24'hFFFFFF;
`endif
    return v;
  endfunction

  task automatic drive(input int c, input int r, input logic [23:0] rgb, input logic tick,
                       input string tag);
    exp_t e;
    @(negedge clk);
    column_addr = 11'(c);
    row_addr    = 10'(r);
    e.rgb  = screen(c, r, rgb);
    e.tick = tick;
    sb.push_back(e);
    tagq.push_back(tag);
  endtask

  task automatic new_frame(input string tag);
    drive(0, 720, 24'h0, 1'b1, tag);
    frames++;
  endtask

  task automatic probe_box(input int bx, input int by);
    logic [7:0]  fc;
    logic [23:0] in_c;
    fc   = 8'(frames);
    in_c = {fc, ~fc, 8'hFF};
    drive(bx, by, in_c, 1'b0, "box_tl");
    drive(bx + 63, by + 63, in_c, 1'b0, "box_br");
    drive(bx + 64, by, 24'h0, 1'b0, "box_right_out");
    drive(bx - 1, by, 24'h0, 1'b0, "box_left_out");
    drive(bx, by - 1, 24'h0, 1'b0, "box_top_out");
  endtask

  task automatic check_reset_state(input string tag);
    @(posedge clk);
    #2;
    checks++;
    assert ({red, green, blue, frame_tick} === 25'd0)
    else begin
      errors++;
      $error("FAIL %s: got rgb=%h tick=%b, want rgb=000000 tick=0", tag,
             {red, green, blue}, frame_tick);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      mon_t = tagq.pop_front();
      checks++;
      assert ({red, green, blue} === mon_e.rgb && frame_tick === mon_e.tick)
      else begin
        errors++;
        $error("FAIL %s: got rgb=%h tick=%b, want rgb=%h tick=%b", mon_t,
               {red, green, blue}, frame_tick, mon_e.rgb, mon_e.tick);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst         = 1'b0;
    mode        = 2'd0;
    column_addr = 11'd0;
    row_addr    = 10'd0;

    // Reset held with toggling addresses, including the frame boundary.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      column_addr = (i % 2 == 1) ? 11'd0 : 11'd100;
      row_addr    = (i % 2 == 1) ? 10'd720 : 10'd10;
      check_reset_state("reset_hold");
    end
    @(negedge clk);
    column_addr = 11'd5;
    row_addr    = 10'd5;
    rst         = 1'b1;

    // Colour bars
    drive(5, 5, 24'hFFFFFF, 1'b0, "bar_first");
    drive(159, 10, 24'hFFFFFF, 1'b0, "bar159");
    drive(160, 10, 24'hFFFF00, 1'b0, "bar160");
    drive(500, 10, 24'h00FF00, 1'b0, "bar500");
    drive(800, 10, 24'hFF0000, 1'b0, "bar800");
    drive(1100, 10, 24'h0000FF, 1'b0, "bar1100");
    drive(1279, 10, 24'h000000, 1'b0, "bar1279");
    drive(1280, 10, 24'h000000, 1'b0, "blank1280");

    // Mode change mid-frame is deferred to the boundary
    mode = 2'd1;
    drive(500, 300, 24'h00FF00, 1'b0, "latch_bars");
    drive(160, 400, 24'hFFFF00, 1'b0, "latch_bars2");
    new_frame("tick_f1");
    drive(32, 0, 24'hFFFFFF, 1'b0, "chk_32_0");
    drive(32, 32, 24'h000000, 1'b0, "chk_32_32");
    drive(64, 64, 24'h000000, 1'b0, "chk_64_64");
    drive(0, 8, 24'h000000, 1'b0, "border_0_8");
    drive(64, 719, 24'h000000, 1'b0, "border_64_719");

    // Stalled boundary address fires once
    drive(0, 720, 24'h0, 1'b1, "stall1");
    frames++;
    drive(0, 720, 24'h0, 1'b0, "stall2");
    drive(0, 720, 24'h0, 1'b0, "stall3");

    // Gradient with frame counter on blue, across the 8-bit wrap
    mode = 2'd2;
    drive(1300, 0, 24'h0, 1'b0, "fill");
    for (int f = 0; f < 257; f++) begin
      new_frame("grad_tick");
      drive(300, 200, {8'h2C, 8'hC8, 8'(frames)}, 1'b0, "grad");
    end

    // Reset mid-stream, then bouncing box from a known frame count
    mode = 2'd3;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      rst         = 1'b0;
      column_addr = (i % 2 == 1) ? 11'd0 : 11'd700;
      row_addr    = (i % 2 == 1) ? 10'd720 : 10'd300;
      check_reset_state("reset_mid");
    end
    @(negedge clk);
    column_addr = 11'd5;
    row_addr    = 10'd5;
    rst         = 1'b1;
    frames      = 0;

    for (int f = 1; f <= 305; f++) begin
      new_frame("box_tick");
      case (f)
        1:       probe_box(4, 4);
        164:     probe_box(656, 656);
        165:     probe_box(660, 652);
        304:     probe_box(1216, 96);
        305:     probe_box(1212, 92);
        default: drive(1300, 0, 24'h0, 1'b0, "fill");
      endcase
    end

    repeat (3) @(posedge clk);
    #3;
    checks++;
    assert (sb.size() == 0)
    else begin
      errors++;
      $error("FAIL drain: got %0d pending, want 0", sb.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
